waveform_sequencer: RTL and testbench

//  Drives the waveform lookup block from the other side of its interface.

---
 rtl/eink_pkg.sv | 30 +++
 rtl/waveform_sequencer.sv | 175 +++++++++++++++++
 tb/tb_waveform_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eink_pkg.sv
// Shared e-ink panel definitions: phase-type codes, sequencer states,
// default panel geometry and a counter-width helper.
package eink_pkg;

    localparam logic [1:0] PT_INIT = 2'b00;
    localparam logic [1:0] PT_GC4  = 2'b01;

    localparam int DEF_H_WORDS = 200;
    localparam int DEF_V_LINES = 600;
    localparam int DEF_ADDR_W  = 17;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PSETUP,
        S_PWAIT,
        S_LSTART,
        S_FETCH,
        S_WAIT_RD,
        S_LOOKUP,
        S_EMIT,
        S_LEND,
        S_DONE
    } seq_state_t;

    // Width of a counter that must reach n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/waveform_sequencer.sv
// Waveform sequencer: steps the phase index through one panel update,
// walks the framebuffer once per phase, pushes each word through the
// waveform lookup block and hands the drive word to the source shifter.
// Ports:
//   clk, reset              clock, async active-high reset
//   start, type_sel         begin an update with the given waveform type
//   busy, done              update in progress / one-cycle completion pulse
//   phase, phase_type       lookup-block phase index and waveform type
//   phase_count             phase total returned by the lookup block
//   wf_data_in, wf_data_out framebuffer word to lookup, drive word back
//   fb_addr, fb_rd          framebuffer read address and request
//   fb_rdata, fb_rvalid     framebuffer read data and valid
//   src_data, src_valid,    drive word to the source shifter (valid/ready)
//   src_ready
//   frame_start, line_start, line_end  pass and line markers
module waveform_sequencer
    import eink_pkg::*;
#(
    parameter int H_WORDS = DEF_H_WORDS,
    parameter int V_LINES = DEF_V_LINES,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        type_sel,
    output logic              busy,
    output logic              done,
    output logic [6:0]        phase,
    output logic [1:0]        phase_type,
    input  logic [6:0]        phase_count,
    output logic [15:0]       wf_data_in,
    input  logic [7:0]        wf_data_out,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_rd,
    input  logic [15:0]       fb_rdata,
    input  logic              fb_rvalid,
    output logic [7:0]        src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              frame_start,
    output logic              line_start,
    output logic              line_end
);

    localparam int WW = cnt_w(H_WORDS);
    localparam int LW = cnt_w(V_LINES);
    localparam logic [WW-1:0] W_LAST = WW'(H_WORDS - 1);
    localparam logic [LW-1:0] L_LAST = LW'(V_LINES - 1);

    seq_state_t state, next;

    logic [WW-1:0] word;
    logic [LW-1:0] line;
    logic [6:0]    count;

    logic last_word, last_line, last_phase;

    assign last_word  = (word == W_LAST);
    assign last_line  = (line == L_LAST);
    // count is nonzero whenever LEND is reachable.
    assign last_phase = (phase == count - 7'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next;
    end

    always_comb begin
        next        = state;
        busy        = 1'b1;
        done        = 1'b0;
        fb_rd       = 1'b0;
        frame_start = 1'b0;
        line_start  = 1'b0;
        line_end    = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) next = S_PSETUP;
            end
            S_PSETUP: begin
                // phase_count follows phase_type, latched last cycle.
                next = (phase_count == 7'd0) ? S_DONE : S_PWAIT;
            end
            S_PWAIT: begin
                frame_start = 1'b1;
                next        = S_LSTART;
            end
            S_LSTART: begin
                line_start = 1'b1;
                next       = S_FETCH;
            end
            S_FETCH: begin
                fb_rd = 1'b1;
                next  = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (fb_rvalid) next = S_LOOKUP;
            end
            S_LOOKUP: begin
                next = S_EMIT;
            end
            S_EMIT: begin
                if (src_ready) next = last_word ? S_LEND : S_FETCH;
            end
            S_LEND: begin
                line_end = 1'b1;
                if (last_line) next = last_phase ? S_DONE : S_PWAIT;
                else           next = S_LSTART;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                next = S_IDLE;
            end
            default: begin
                busy = 1'b0;
                next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase      <= '0;
            phase_type <= '0;
            count      <= '0;
            word       <= '0;
            line       <= '0;
            fb_addr    <= '0;
            wf_data_in <= '0;
            src_data   <= '0;
            src_valid  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        phase_type <= type_sel;
                        phase      <= '0;
                        fb_addr    <= '0;
                    end
                end
                S_PSETUP: begin
                    count <= phase_count;
                end
                S_PWAIT: begin
                    line    <= '0;
                    word    <= '0;
                    fb_addr <= '0;
                end
                S_WAIT_RD: begin
                    if (fb_rvalid) wf_data_in <= fb_rdata;
                end
                S_LOOKUP: begin
                    src_data  <= wf_data_out;
                    src_valid <= 1'b1;
                end
                S_EMIT: begin
                    if (src_ready) begin
                        src_valid <= 1'b0;
                        fb_addr   <= fb_addr + ADDR_W'(1);
                        word      <= last_word ? '0 : word + WW'(1);
                    end
                end
                S_LEND: begin
                    if (last_line) phase <= phase + 7'd1;
                    else           line  <= line + LW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_waveform_sequencer.sv
// Self-checking bench for waveform_sequencer: small 2x2 panel, a
// waveform stub and a framebuffer model with adjustable read latency.
module tb_waveform_sequencer;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    type_sel;
    logic          busy, done;
    logic [6:0]    phase;
    logic [1:0]    phase_type;
    logic [6:0]    phase_count;
    logic [15:0]   wf_data_in;
    logic [7:0]    wf_data_out;
    logic [AW-1:0] fb_addr;
    logic          fb_rd;
    logic [15:0]   fb_rdata;
    logic          fb_rvalid;
    logic [7:0]    src_data;
    logic          src_valid, src_ready;
    logic          frame_start, line_start, line_end;

    logic [6:0]  stub_cnt;
    logic [15:0] mem [4];
    int          lat;

    int errors = 0;
    int checks = 0;

    int n_fs = 0, n_ls = 0, n_le = 0, n_done = 0;
    int n_rd = 0, n_sv = 0, n_acc = 0;
    int b_fs, b_ls, b_le, b_done, b_rd, b_sv, b_acc;

    logic [7:0]    exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [15:0]   prev_wf = '0;
    logic          prev_rv = 1'b0;

    assign phase_count = stub_cnt;
    assign wf_data_out = wf_data_in[7:0] ^ {1'b0, phase};

    waveform_sequencer #(
        .H_WORDS(2),
        .V_LINES(2),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .type_sel   (type_sel),
        .busy       (busy),
        .done       (done),
        .phase      (phase),
        .phase_type (phase_type),
        .phase_count(phase_count),
        .wf_data_in (wf_data_in),
        .wf_data_out(wf_data_out),
        .fb_addr    (fb_addr),
        .fb_rd      (fb_rd),
        .fb_rdata   (fb_rdata),
        .fb_rvalid  (fb_rvalid),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .frame_start(frame_start),
        .line_start (line_start),
        .line_end   (line_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {busy, done, phase, phase_type, wf_data_in, fb_addr, fb_rd,
                src_data, src_valid, frame_start, line_start, line_end};
    endfunction

    task automatic mon_step();
        if (reset) begin
            prev_wf = wf_data_in;
            prev_rv = 1'b0;
            return;
        end
        n_fs   += int'(frame_start);
        n_ls   += int'(line_start);
        n_le   += int'(line_end);
        n_done += int'(done);
        n_sv   += int'(src_valid);
        if (fb_rd) begin
            n_rd++;
            if (addr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL fb_rd_extra: got addr 0x%0h, expected no read", fb_addr);
            end else begin
                check("fb_addr", 64'(fb_addr), 64'(addr_q.pop_front()));
            end
        end
        if (src_valid && src_ready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL src_extra: got 0x%0h, expected no word", src_data);
            end else begin
                check("src_data", 64'(src_data), 64'(exp_q.pop_front()));
            end
        end
        if (wf_data_in != prev_wf) check("wf_on_rvalid", 64'(prev_rv), 64'd1);
        prev_wf = wf_data_in;
        prev_rv = fb_rvalid;
    endtask

    task automatic mem_step();
        logic [1:0] a;
        a = fb_addr[1:0];
        repeat (lat) @(posedge clk);
        #1;
        fb_rdata  = mem[a];
        fb_rvalid = 1'b1;
        @(posedge clk);
        #1;
        fb_rvalid = 1'b0;
    endtask

    task automatic snap();
        b_fs = n_fs; b_ls = n_ls; b_le = n_le; b_done = n_done;
        b_rd = n_rd; b_sv = n_sv; b_acc = n_acc;
    endtask

    task automatic begin_update(input int cnt, input logic [1:0] t);
        for (int p = 0; p < cnt; p++)
            for (int a = 0; a < 4; a++) begin
                exp_q.push_back(mem[a][7:0] ^ 8'(p));
                addr_q.push_back(AW'(a));
            end
        snap();
        @(posedge clk); #1;
        start = 1'b1; type_sel = t;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'd1);
        check("phase_type", 64'(phase_type), 64'(t));
    endtask

    task automatic finish_update(input int cnt);
        int i;
        i = 0;
        while (n_done == b_done && i < 3000) begin
            @(posedge clk);
            i++;
        end
        if (n_done == b_done) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done, expected done within 3000 cycles");
        end
        @(negedge clk);
        check("busy_end", 64'(busy), 64'd0);
        check("phase_final", 64'(phase), 64'(cnt));
        check("n_frame_start", 64'(n_fs - b_fs), 64'(cnt));
        check("n_line_start", 64'(n_ls - b_ls), 64'(2 * cnt));
        check("n_line_end", 64'(n_le - b_le), 64'(2 * cnt));
        check("n_words", 64'(n_acc - b_acc), 64'(4 * cnt));
        check("n_fb_rd", 64'(n_rd - b_rd), 64'(4 * cnt));
        check("n_done", 64'(n_done - b_done), 64'd1);
        check("words_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; type_sel = 2'b00; src_ready = 1'b1;
        fb_rvalid = 1'b0; fb_rdata = '0; stub_cnt = 7'd3; lat = 1;
        for (int a = 0; a < 4; a++) mem[a] = 16'h00A5;

        fork
            forever begin @(negedge clk); mon_step(); end
            forever begin @(negedge clk); if (fb_rd) mem_step(); end
        join_none

        @(negedge clk);
        check("reset_outputs", outs(), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // INIT update, A5 everywhere: A5 x4, A4 x4, A7 x4.
        begin_update(3, 2'b00);
        finish_update(3);

        // GC4 update with a second start while busy.
        begin_update(3, 2'b01);
        repeat (15) @(posedge clk);
        #1; start = 1'b1; type_sel = 2'b10;
        @(posedge clk); #1; start = 1'b0;
        finish_update(3);
        check("type_kept", 64'(phase_type), 64'd1);
        snap();
        repeat (4) @(negedge clk);
        check("idle_after_ignored_start", 64'({busy, 1'b0} | 2'(n_rd - b_rd)), 64'd0);

        // Shifter stall on the first word.
        mem[0] = 16'h1234; mem[1] = 16'hBEEF; mem[2] = 16'h0F0F; mem[3] = 16'h55AA;
        src_ready = 1'b0;
        begin_update(3, 2'b01);
        begin
            int i;
            logic [7:0] d;
            i = 0;
            while (!src_valid && i < 100) begin @(posedge clk); #1; i++; end
            @(negedge clk);
            d = src_data;
            check("stall_first_word", 64'(d), 64'h34);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                check("stall_valid", 64'(src_valid), 64'd1);
                check("stall_data", 64'(src_data), 64'(d));
                check("stall_no_rd", 64'(fb_rd), 64'd0);
            end
            @(posedge clk); #1;
            src_ready = 1'b1;
        end
        finish_update(3);

        // Slow framebuffer: 5-cycle read latency.
        mem[0] = 16'h00C3; mem[1] = 16'h003C; mem[2] = 16'h0081; mem[3] = 16'h007E;
        lat = 5;
        begin_update(3, 2'b00);
        finish_update(3);
        lat = 1;

        // Zero phases: done two cycles after start, no traffic.
        stub_cnt = 7'd0;
        snap();
        @(posedge clk); #1; start = 1'b1; type_sel = 2'b00;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        check("cnt0_setup_done", 64'(done), 64'd0);
        @(negedge clk);
        check("cnt0_done", 64'(done), 64'd1);
        repeat (3) @(negedge clk);
        check("cnt0_no_rd", 64'(n_rd - b_rd), 64'd0);
        check("cnt0_no_valid", 64'(n_sv - b_sv), 64'd0);
        check("cnt0_busy", 64'(busy), 64'd0);
        stub_cnt = 7'd3;

        // Reset in the middle of phase 1, then a clean update.
        begin_update(3, 2'b00);
        begin
            int i;
            i = 0;
            while (phase != 7'd1 && i < 500) begin @(posedge clk); #1; i++; end
            check("reached_phase1", 64'(phase), 64'd1);
        end
        repeat (3) @(posedge clk);
        #2; reset = 1'b1;
        #1;
        check("midrun_reset_outputs", outs(), 64'd0);
        snap();
        repeat (3) @(posedge clk);
        #1; reset = 1'b0;
        exp_q.delete();
        addr_q.delete();
        repeat (6) @(negedge clk);
        check("rst_no_done", 64'(n_done - b_done), 64'd0);
        check("rst_no_rd", 64'(n_rd - b_rd), 64'd0);
        begin_update(3, 2'b01);
        finish_update(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
